sram_port_ctrl: RTL and testbench

Registered single-port asynchronous-SRAM controller. It is the successor to the plain bidirectional bus buffer. Accepts read/write requests over a valid/ready handshake, then sequences CE_N/OE_N/WE_N/byte-enables with a parametrised access time. Adds byte-lane writes and guaranteed bus turnaround. Sits between the CPU/GPU memory arbiter and the board SRAM pins.

---
 rtl/sram_port_ctrl.sv | 102 ++++++++++
 tb/tb_sram_port_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/sram_port_ctrl.sv
// sram_port_ctrl: registered async-SRAM port controller with valid/ready requests,
// byte-lane writes, a write hold cycle and read-to-next-request bus turnaround.
module sram_port_ctrl #(
    parameter int DW   = 16,
    parameter int AW   = 20,
    parameter int WAIT = 2,
    parameter int TURN = 1
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [AW-1:0]   req_addr,
    input  logic [DW-1:0]   req_wdata,
    input  logic [DW/8-1:0] req_be,
    output logic            rsp_valid,
    output logic [DW-1:0]   rsp_rdata,
    output logic [AW-1:0]   SRAM_ADDR,
    inout  wire  [DW-1:0]   SRAM_DQ,
    output logic            SRAM_CE_N,
    output logic            SRAM_OE_N,
    output logic            SRAM_WE_N,
    output logic [DW/8-1:0] SRAM_BE_N
);
    localparam int NB = DW / 8;
    localparam int MX = WAIT > TURN ? WAIT : TURN;
    localparam int CW = $clog2(MX + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, HOLD, TRN} state_t;

    state_t          state, nxt;
    logic [CW-1:0]   cnt;
    logic [DW-1:0]   wdata_q;
    logic [NB-1:0]   be_q, be_n, be_d;
    logic            we_q, cur_we, accept, last, rd_done;
    logic            ce_d, oe_d, we_d, drive_d, drive;

    assign req_ready = state == IDLE;
    assign accept    = req_valid & req_ready;
    assign last      = cnt == '0;
    assign rd_done   = state == ACCESS && last && !we_q;
    assign cur_we    = accept ? req_we : we_q;
    assign be_n      = accept ? req_be : be_q;
    assign SRAM_DQ   = drive ? wdata_q : 'z;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            cnt       <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            we_q      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            SRAM_ADDR <= '0;
            SRAM_CE_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
            SRAM_WE_N <= 1'b1;
            SRAM_BE_N <= '1;
            drive     <= 1'b0;
        end else begin
            state     <= nxt;
            cnt       <= accept ? CW'(WAIT - 1) :
                         rd_done ? CW'(TURN > 0 ? TURN - 1 : 0) :
                         last ? cnt : cnt - 1'b1;
            if (accept) begin
                wdata_q   <= req_wdata;
                be_q      <= req_be;
                we_q      <= req_we;
                SRAM_ADDR <= req_addr;
            end
            rsp_valid <= state == ACCESS && last;
            if (rd_done) rsp_rdata <= SRAM_DQ;
            SRAM_CE_N <= ce_d;
            SRAM_OE_N <= oe_d;
            SRAM_WE_N <= we_d;
            SRAM_BE_N <= be_d;
            drive     <= drive_d;
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = req_valid ? ACCESS : IDLE;
            ACCESS:  if (last) nxt = we_q ? HOLD : (TURN > 0 ? TRN : IDLE);
            HOLD:    nxt = IDLE;
            TRN:     if (last) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Pin values are computed for the coming state and registered, so the pins never see req_* directly.
    always_comb begin
        ce_d    = !(nxt == ACCESS || nxt == HOLD);
        oe_d    = !(nxt == ACCESS && !cur_we);
        we_d    = !(nxt == ACCESS && cur_we);
        drive_d = (nxt == ACCESS || nxt == HOLD) && cur_we;
        be_d    = nxt == ACCESS ? (cur_we ? ~be_n : '0) : nxt == HOLD ? ~be_q : '1;
    end
endmodule

// File: tb/tb_sram_port_ctrl.sv
// tb_sram_port_ctrl: table-driven cycle-by-cycle check of two controller builds
// (WAIT=2/TURN=1 and WAIT=1/TURN=0), each attached to a small byte-lane SRAM model.
module tb_sram_port_ctrl;
    logic        Clk, Reset, req_valid, req_we;
    logic [19:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_be;

    logic        rdy_a, rv_a, ce_a, oe_a, we_a, rdy_b, rv_b, ce_b, oe_b, we_b;
    logic [15:0] rd_a, rd_b;
    logic [19:0] addr_a, addr_b;
    logic [1:0]  be_a, be_b;
    wire  [15:0] dq_a, dq_b;

    logic [15:0] mem_a [0:1023];
    logic [15:0] mem_b [0:1023];

    int tests = 0;
    int fails = 0;

    sram_port_ctrl #(.DW(16), .AW(20), .WAIT(2), .TURN(1)) u_a (
        .Clk(Clk), .Reset(Reset), .req_valid(req_valid), .req_ready(rdy_a), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rv_a),
        .rsp_rdata(rd_a), .SRAM_ADDR(addr_a), .SRAM_DQ(dq_a), .SRAM_CE_N(ce_a),
        .SRAM_OE_N(oe_a), .SRAM_WE_N(we_a), .SRAM_BE_N(be_a)
    );

    sram_port_ctrl #(.DW(16), .AW(20), .WAIT(1), .TURN(0)) u_b (
        .Clk(Clk), .Reset(Reset), .req_valid(req_valid), .req_ready(rdy_b), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rv_b),
        .rsp_rdata(rd_b), .SRAM_ADDR(addr_b), .SRAM_DQ(dq_b), .SRAM_CE_N(ce_b),
        .SRAM_OE_N(oe_b), .SRAM_WE_N(we_b), .SRAM_BE_N(be_b)
    );

    // SRAM models: drive the bus while CE_N and OE_N are low, write enabled lanes while WE_N is low.
    assign dq_a = (!ce_a && !oe_a) ? mem_a[addr_a[9:0]] : 16'hzzzz;
    assign dq_b = (!ce_b && !oe_b) ? mem_b[addr_b[9:0]] : 16'hzzzz;

    always @(posedge Clk)
        if (Reset) begin
            mem_a[10'h123] <= 16'hBEEF;
            mem_a[10'h010] <= 16'h1122;
        end else if (!ce_a && !we_a) begin
            if (!be_a[0]) mem_a[addr_a[9:0]][7:0]  <= dq_a[7:0];
            if (!be_a[1]) mem_a[addr_a[9:0]][15:8] <= dq_a[15:8];
        end

    always @(posedge Clk)
        if (Reset) begin
            mem_b[10'h200] <= 16'hBEEF;
            mem_b[10'h300] <= 16'h1122;
        end else if (!ce_b && !we_b) begin
            if (!be_b[0]) mem_b[addr_b[9:0]][7:0]  <= dq_b[7:0];
            if (!be_b[1]) mem_b[addr_b[9:0]][15:8] <= dq_b[15:8];
        end

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        bit          b, ck, rst, v, we;
        logic [19:0] a;
        logic [15:0] wd;
        logic [1:0]  be;
        bit          rdy, rv, ce, oe, wn;
        logic [1:0]  ben;
        bit          dz;
        logic [15:0] dq, rd;
        logic [19:0] ea;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(input bit b, ck, rst, v, we, input logic [19:0] a,
                                input logic [15:0] wd, input logic [1:0] be,
                                input bit rdy, rv, ce, oe, wn, input logic [1:0] ben,
                                input bit dz, input logic [15:0] dq, rd, input logic [19:0] ea);
        vec_t t;
        t.b = b; t.ck = ck; t.rst = rst; t.v = v; t.we = we; t.a = a; t.wd = wd; t.be = be;
        t.rdy = rdy; t.rv = rv; t.ce = ce; t.oe = oe; t.wn = wn; t.ben = ben;
        t.dz = dz; t.dq = dq; t.rd = rd; t.ea = ea;
        return t;
    endfunction

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s vec %0d: got %h want %h", nm, i, act, exp);
        end
    endtask

    localparam logic [19:0] RA = 20'h00123, WA = 20'h00010, W2 = 20'h00020, A3 = 20'h00030;
    localparam logic [19:0] RB = 20'h00200, WB = 20'h00300;

    initial begin
        Reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        //                b ck rs v we addr wdata     be     rdy rv ce oe wn ben   dz dq        rdata     eaddr
        tv.push_back(mk(0, 1, 1, 0, 0, 0,  16'h0,    2'b00, 1, 0, 1, 1, 1, 2'b11, 1, 16'h0,    16'h0,    0));
        tv.push_back(mk(0, 1, 0, 0, 0, 0,  16'h0,    2'b00, 1, 0, 1, 1, 1, 2'b11, 1, 16'h0,    16'h0,    0));
        tv.push_back(mk(0, 1, 0, 1, 0, RA, 16'h0,    2'b00, 1, 0, 1, 1, 1, 2'b11, 1, 16'h0,    16'h0,    0));
        tv.push_back(mk(0, 1, 0, 0, 0, 0,  16'h0,    2'b00, 0, 0, 0, 0, 1, 2'b00, 0, 16'hBEEF, 16'h0,    RA));
        tv.push_back(mk(0, 1, 0, 0, 0, 0,  16'h0,    2'b00, 0, 0, 0, 0, 1, 2'b00, 0, 16'hBEEF, 16'h0,    RA));
        tv.push_back(mk(0, 1, 0, 0, 0, 0,  16'h0,    2'b00, 0, 1, 1, 1, 1, 2'b11, 1, 16'h0,    16'hBEEF, RA));
        tv.push_back(mk(0, 1, 0, 1, 1, WA, 16'hA5C3, 2'b01, 1, 0, 1, 1, 1, 2'b11, 1, 16'h0,    16'hBEEF, RA));
        tv.push_back(mk(0, 1, 0, 0, 0, 0,  16'h0,    2'b00, 0, 0, 0, 1, 0, 2'b10, 0, 16'hA5C3, 16'hBEEF, WA));
        tv.push_back(mk(0, 1, 0, 0, 0, 0,  16'h0,    2'b00, 0, 0, 0, 1, 0, 2'b10, 0, 16'hA5C3, 16'hBEEF, WA));
        tv.push_back(mk(0, 1, 0, 0, 0, 0,  16'h0,    2'b00, 0, 1, 0, 1, 1, 2'b10, 0, 16'hA5C3, 16'hBEEF, WA));
        tv.push_back(mk(0, 1, 0, 1, 0, WA, 16'h0,    2'b00, 1, 0, 1, 1, 1, 2'b11, 1, 16'h0,    16'hBEEF, WA));
        tv.push_back(mk(0, 1, 0, 0, 0, 0,  16'h0,    2'b00, 0, 0, 0, 0, 1, 2'b00, 0, 16'h11C3, 16'hBEEF, WA));
        tv.push_back(mk(0, 1, 0, 0, 0, 0,  16'h0,    2'b00, 0, 0, 0, 0, 1, 2'b00, 0, 16'h11C3, 16'hBEEF, WA));
        tv.push_back(mk(0, 1, 0, 0, 0, 0,  16'h0,    2'b00, 0, 1, 1, 1, 1, 2'b11, 1, 16'h0,    16'h11C3, WA));
        tv.push_back(mk(0, 1, 0, 1, 0, RA, 16'h0,    2'b00, 1, 0, 1, 1, 1, 2'b11, 1, 16'h0,    16'h11C3, WA));
        tv.push_back(mk(0, 1, 0, 1, 1, W2, 16'h5A5A, 2'b11, 0, 0, 0, 0, 1, 2'b00, 0, 16'hBEEF, 16'h11C3, RA));
        tv.push_back(mk(0, 1, 0, 1, 1, W2, 16'h5A5A, 2'b11, 0, 0, 0, 0, 1, 2'b00, 0, 16'hBEEF, 16'h11C3, RA));
        tv.push_back(mk(0, 1, 0, 1, 1, W2, 16'h5A5A, 2'b11, 0, 1, 1, 1, 1, 2'b11, 1, 16'h0,    16'hBEEF, RA));
        tv.push_back(mk(0, 1, 0, 1, 1, W2, 16'h5A5A, 2'b11, 1, 0, 1, 1, 1, 2'b11, 1, 16'h0,    16'hBEEF, RA));
        tv.push_back(mk(0, 1, 0, 0, 0, 0,  16'h0,    2'b00, 0, 0, 0, 1, 0, 2'b00, 0, 16'h5A5A, 16'hBEEF, W2));
        tv.push_back(mk(0, 1, 0, 0, 0, 0,  16'h0,    2'b00, 0, 0, 0, 1, 0, 2'b00, 0, 16'h5A5A, 16'hBEEF, W2));
        tv.push_back(mk(0, 1, 0, 0, 0, 0,  16'h0,    2'b00, 0, 1, 0, 1, 1, 2'b00, 0, 16'h5A5A, 16'hBEEF, W2));
        tv.push_back(mk(0, 1, 0, 0, 0, 0,  16'h0,    2'b00, 1, 0, 1, 1, 1, 2'b11, 1, 16'h0,    16'hBEEF, W2));
        tv.push_back(mk(0, 1, 0, 1, 1, A3, 16'hFFFF, 2'b11, 1, 0, 1, 1, 1, 2'b11, 1, 16'h0,    16'hBEEF, W2));
        tv.push_back(mk(0, 1, 1, 0, 0, 0,  16'h0,    2'b00, 0, 0, 0, 1, 0, 2'b00, 0, 16'hFFFF, 16'hBEEF, A3));
        tv.push_back(mk(0, 1, 0, 0, 0, 0,  16'h0,    2'b00, 1, 0, 1, 1, 1, 2'b11, 1, 16'h0,    16'h0,    0));
        tv.push_back(mk(0, 1, 0, 1, 0, RA, 16'h0,    2'b00, 1, 0, 1, 1, 1, 2'b11, 1, 16'h0,    16'h0,    0));
        tv.push_back(mk(0, 1, 0, 0, 0, 0,  16'h0,    2'b00, 0, 0, 0, 0, 1, 2'b00, 0, 16'hBEEF, 16'h0,    RA));
        tv.push_back(mk(0, 1, 0, 0, 0, 0,  16'h0,    2'b00, 0, 0, 0, 0, 1, 2'b00, 0, 16'hBEEF, 16'h0,    RA));
        tv.push_back(mk(0, 1, 0, 0, 0, 0,  16'h0,    2'b00, 0, 1, 1, 1, 1, 2'b11, 1, 16'h0,    16'hBEEF, RA));
        tv.push_back(mk(0, 1, 0, 0, 0, 0,  16'h0,    2'b00, 1, 0, 1, 1, 1, 2'b11, 1, 16'h0,    16'hBEEF, RA));
        tv.push_back(mk(1, 0, 1, 0, 0, 0,  16'h0,    2'b00, 1, 0, 1, 1, 1, 2'b11, 1, 16'h0,    16'h0,    0));
        tv.push_back(mk(1, 1, 1, 0, 0, 0,  16'h0,    2'b00, 1, 0, 1, 1, 1, 2'b11, 1, 16'h0,    16'h0,    0));
        tv.push_back(mk(1, 1, 0, 0, 0, 0,  16'h0,    2'b00, 1, 0, 1, 1, 1, 2'b11, 1, 16'h0,    16'h0,    0));
        tv.push_back(mk(1, 1, 0, 1, 0, RB, 16'h0,    2'b00, 1, 0, 1, 1, 1, 2'b11, 1, 16'h0,    16'h0,    0));
        tv.push_back(mk(1, 1, 0, 0, 0, 0,  16'h0,    2'b00, 0, 0, 0, 0, 1, 2'b00, 0, 16'hBEEF, 16'h0,    RB));
        tv.push_back(mk(1, 1, 0, 1, 1, WB, 16'hA5C3, 2'b01, 1, 1, 1, 1, 1, 2'b11, 1, 16'h0,    16'hBEEF, RB));
        tv.push_back(mk(1, 1, 0, 0, 0, 0,  16'h0,    2'b00, 0, 0, 0, 1, 0, 2'b10, 0, 16'hA5C3, 16'hBEEF, WB));
        tv.push_back(mk(1, 1, 0, 1, 0, WB, 16'h0,    2'b00, 0, 1, 0, 1, 1, 2'b10, 0, 16'hA5C3, 16'hBEEF, WB));
        tv.push_back(mk(1, 1, 0, 1, 0, WB, 16'h0,    2'b00, 1, 0, 1, 1, 1, 2'b11, 1, 16'h0,    16'hBEEF, WB));
        tv.push_back(mk(1, 1, 0, 0, 0, 0,  16'h0,    2'b00, 0, 0, 0, 0, 1, 2'b00, 0, 16'h11C3, 16'hBEEF, WB));
        tv.push_back(mk(1, 1, 0, 0, 0, 0,  16'h0,    2'b00, 1, 1, 1, 1, 1, 2'b11, 1, 16'h0,    16'h11C3, WB));
        tv.push_back(mk(1, 1, 0, 0, 0, 0,  16'h0,    2'b00, 1, 0, 1, 1, 1, 2'b11, 1, 16'h0,    16'h11C3, WB));

        @(posedge Clk);
        #1;
        foreach (tv[i]) begin
            Reset = tv[i].rst; req_valid = tv[i].v; req_we = tv[i].we;
            req_addr = tv[i].a; req_wdata = tv[i].wd; req_be = tv[i].be;
            @(negedge Clk);
            if (tv[i].ck) begin
                chk("req_ready", i, tv[i].b ? rdy_b : rdy_a, tv[i].rdy);
                chk("rsp_valid", i, tv[i].b ? rv_b : rv_a, tv[i].rv);
                chk("rsp_rdata", i, tv[i].b ? rd_b : rd_a, tv[i].rd);
                chk("ce_n", i, tv[i].b ? ce_b : ce_a, tv[i].ce);
                chk("oe_n", i, tv[i].b ? oe_b : oe_a, tv[i].oe);
                chk("we_n", i, tv[i].b ? we_b : we_a, tv[i].wn);
                chk("be_n", i, tv[i].b ? be_b : be_a, tv[i].ben);
                chk("sram_addr", i, tv[i].b ? addr_b : addr_a, tv[i].ea);
                if (tv[i].dz) chk("bus_released", i, tv[i].b ? u_b.drive : u_a.drive, 0);
                else          chk("dq", i, tv[i].b ? dq_b : dq_a, tv[i].dq);
            end
            @(posedge Clk);
            #1;
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
